wave_capture: RTL

Waveform capture block: the receiving end of the 10-bit parallel sample bus that the ROM-driven sine generator drives onto pins D0..D9. It synchronizes an asynchronous 10-bit sample bus, arms on request, triggers on a rising threshold crossing, and stores a fixed-length record in on-chip RAM. It also reports the record's min/max and the period between consecutive rising crossings. Used for loopback self-test of the DAC output path and for bench inspection of captured waveforms.

---
 rtl/wave_capture.sv | 179 +++++++++++++++++
 1 files changed

// File: rtl/wave_capture.sv
// wave_capture: synchronizes an asynchronous sample bus, arms on request,
// triggers on a rising threshold crossing and stores a fixed-length record.
// Also tracks record min/max and the period between consecutive crossings.
module wave_capture #(
  parameter int unsigned DATA_WIDTH   = 10,
  parameter int unsigned ADDR_WIDTH   = 7,
  parameter int unsigned PERIOD_WIDTH = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [DATA_WIDTH-1:0]   sample_in,
  input  logic [DATA_WIDTH-1:0]   trig_level,
  input  logic                    arm,
  output logic                    busy,
  output logic                    capture_done,
  input  logic [ADDR_WIDTH-1:0]   rd_addr,
  output logic [DATA_WIDTH-1:0]   rd_data,
  output logic [DATA_WIDTH-1:0]   min_val,
  output logic [DATA_WIDTH-1:0]   max_val,
  output logic [PERIOD_WIDTH-1:0] period,
  output logic                    period_valid
);

  localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;
  localparam logic [ADDR_WIDTH-1:0]   LAST_ADDR  = ADDR_WIDTH'(DEPTH - 1);
  localparam logic [PERIOD_WIDTH-1:0] PERIOD_MAX = '1;
  localparam logic [DATA_WIDTH-1:0]   DATA_MAX   = '1;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ARMED,
    ST_CAPTURE,
    ST_DONE
  } state_t;

  state_t                  state_q, state_d;
  logic [DATA_WIDTH-1:0]   sync1_q, sync1_d;
  logic [DATA_WIDTH-1:0]   s_q, s_d;
  logic [DATA_WIDTH-1:0]   s_prev_q, s_prev_d;
  logic [ADDR_WIDTH-1:0]   wr_addr_q, wr_addr_d;
  logic [DATA_WIDTH-1:0]   min_q, min_d;
  logic [DATA_WIDTH-1:0]   max_q, max_d;
  logic [PERIOD_WIDTH-1:0] cnt_q, cnt_d;
  logic                    cnt_run_q, cnt_run_d;
  logic [PERIOD_WIDTH-1:0] period_q, period_d;
  logic                    period_valid_q, period_valid_d;
  logic                    done_q, done_d;
  logic                    busy_q, busy_d;
  logic [DATA_WIDTH-1:0]   rd_data_q, rd_data_d;
  logic                    crossing_c;
  logic                    wr_en_c;

  logic [DATA_WIDTH-1:0]   mem_q [DEPTH];

  assign crossing_c = (s_prev_q < trig_level) && (s_q >= trig_level);

  // Next-state, capture control, min/max tracking and period measurement.
  always_comb begin
    state_d        = state_q;
    sync1_d        = sample_in;
    s_d            = sync1_q;
    s_prev_d       = s_q;
    wr_addr_d      = wr_addr_q;
    min_d          = min_q;
    max_d          = max_q;
    cnt_d          = cnt_q;
    cnt_run_d      = cnt_run_q;
    period_d       = period_q;
    period_valid_d = period_valid_q;
    done_d         = done_q;
    busy_d         = busy_q;
    rd_data_d      = mem_q[rd_addr];
    wr_en_c        = 1'b0;

    // Period counter runs independently of the capture; arm below overrides it.
    if (cnt_run_q) begin
      if (crossing_c) begin
        period_d       = cnt_q;
        period_valid_d = 1'b1;
        cnt_run_d      = 1'b0;
      end else if (cnt_q == PERIOD_MAX) begin
        period_d       = PERIOD_MAX;
        period_valid_d = 1'b1;
        cnt_run_d      = 1'b0;
      end else begin
        cnt_d = cnt_q + PERIOD_WIDTH'(1);
      end
    end

    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (arm) begin
          state_d        = ST_ARMED;
          busy_d         = 1'b1;
          done_d         = 1'b0;
          period_valid_d = 1'b0;
          period_d       = '0;
          cnt_run_d      = 1'b0;
          cnt_d          = '0;
          min_d          = DATA_MAX;
          max_d          = '0;
          wr_addr_d      = '0;
        end
      end
      ST_ARMED: begin
        if (crossing_c) begin
          state_d   = ST_CAPTURE;
          wr_en_c   = 1'b1;
          wr_addr_d = wr_addr_q + ADDR_WIDTH'(1);
          min_d     = (s_q < min_q) ? s_q : min_q;
          max_d     = (s_q > max_q) ? s_q : max_q;
          cnt_d     = PERIOD_WIDTH'(1);
          cnt_run_d = 1'b1;
        end
      end
      ST_CAPTURE: begin
        wr_en_c   = 1'b1;
        wr_addr_d = wr_addr_q + ADDR_WIDTH'(1);
        min_d     = (s_q < min_q) ? s_q : min_q;
        max_d     = (s_q > max_q) ? s_q : max_q;
        if (wr_addr_q == LAST_ADDR) begin
          state_d = ST_DONE;
          done_d  = 1'b1;
          busy_d  = 1'b0;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and output registers with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= ST_IDLE;
      sync1_q        <= '0;
      s_q            <= '0;
      s_prev_q       <= '0;
      wr_addr_q      <= '0;
      min_q          <= DATA_MAX;
      max_q          <= '0;
      cnt_q          <= '0;
      cnt_run_q      <= 1'b0;
      period_q       <= '0;
      period_valid_q <= 1'b0;
      done_q         <= 1'b0;
      busy_q         <= 1'b0;
      rd_data_q      <= '0;
    end else begin
      state_q        <= state_d;
      sync1_q        <= sync1_d;
      s_q            <= s_d;
      s_prev_q       <= s_prev_d;
      wr_addr_q      <= wr_addr_d;
      min_q          <= min_d;
      max_q          <= max_d;
      cnt_q          <= cnt_d;
      cnt_run_q      <= cnt_run_d;
      period_q       <= period_d;
      period_valid_q <= period_valid_d;
      done_q         <= done_d;
      busy_q         <= busy_d;
      rd_data_q      <= rd_data_d;
    end
  end

  // Capture buffer write port; contents survive reset.
  always_ff @(posedge clk) begin
    if (wr_en_c) mem_q[wr_addr_q] <= s_q;
  end

  assign busy         = busy_q;
  assign capture_done = done_q;
  assign rd_data      = rd_data_q;
  assign min_val      = min_q;
  assign max_val      = max_q;
  assign period       = period_q;
  assign period_valid = period_valid_q;

endmodule
